multicycle_alu: RTL and testbench

Parametrised, registered ALU with an iterative multiply/divide unit and HI/LO registers, used by the multi-cycle MIPS datapath in place of the purely combinational single-cycle ALU. It keeps the 4-bit operation encoding for AND/OR/ADD/SUB/SLT/NOR and adds XOR, SLTU, MULT(U), DIV(U), MFHI and MFLO. A start/busy/done handshake lets the control FSM stall while multi-cycle operations run.

---
 rtl/alu_pkg.sv | 41 ++++
 rtl/muldiv_unit.sv | 174 +++++++++++++++++
 rtl/multicycle_alu.sv | 132 +++++++++++++
 tb/tb_multicycle_alu.sv | 308 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared definitions for multicycle_alu and its multiply/divide unit.
//   - 4-bit operation encodings (MIPS-style ALU control plus extensions)
//   - state encoding for the iterative multiply/divide sequencer
//   - small opcode classification helpers
package alu_pkg;

  localparam logic [3:0] OP_AND   = 4'b0000;
  localparam logic [3:0] OP_OR    = 4'b0001;
  localparam logic [3:0] OP_ADD   = 4'b0010;
  localparam logic [3:0] OP_XOR   = 4'b0011;
  localparam logic [3:0] OP_SUB   = 4'b0110;
  localparam logic [3:0] OP_SLT   = 4'b0111;
  localparam logic [3:0] OP_SLTU  = 4'b1000;
  localparam logic [3:0] OP_MULT  = 4'b1001;
  localparam logic [3:0] OP_MULTU = 4'b1010;
  localparam logic [3:0] OP_DIV   = 4'b1011;
  localparam logic [3:0] OP_NOR   = 4'b1100;
  localparam logic [3:0] OP_DIVU  = 4'b1101;
  localparam logic [3:0] OP_MFHI  = 4'b1110;
  localparam logic [3:0] OP_MFLO  = 4'b1111;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_DIV  = 2'd2,
    ST_SIGN = 2'd3
  } alu_state_e;

  function automatic logic is_muldiv_op(input logic [3:0] op);
    return (op == OP_MULT) || (op == OP_MULTU) || (op == OP_DIV) || (op == OP_DIVU);
  endfunction

  function automatic logic is_div_op(input logic [3:0] op);
    return (op == OP_DIV) || (op == OP_DIVU);
  endfunction

  function automatic logic is_signed_muldiv(input logic [3:0] op);
    return (op == OP_MULT) || (op == OP_DIV);
  endfunction

endpackage

// File: rtl/muldiv_unit.sv
// Iterative multiply/divide unit with HI/LO registers.
// Only instantiated when MULTICYCLE_ALU_MULDIV_EN is defined.
//
// Shift-add multiplier and restoring divider, one bit per cycle on the
// operand magnitudes; the SIGN state applies the sign correction and
// commits HI/LO. Divide by zero completes straight from IDLE.
//
// State table:
//   state   | meaning
//   IDLE    | waiting for an accepted mult/div; div-by-zero completes here
//   MUL     | shift-add iteration, WIDTH cycles
//   DIV     | restoring-divide iteration, WIDTH cycles
//   SIGN    | sign correction, HI/LO written, complete asserted
//
// Ports:
//   clk, reset        clock, async active-high reset
//   accept            start accepted by the top (start & ~busy)
//   operation         opcode, only mult/div opcodes launch work here
//   operand1/2        dividend|multiplicand / divisor|multiplier
//   busy              iteration or sign correction in progress
//   complete          HI/LO being written this cycle (combinational)
//   lo_next           value LO takes at this edge, forwarded to result
//   hi, lo            HI/LO registers
module muldiv_unit
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             accept,
  input  logic [3:0]       operation,
  input  logic [WIDTH-1:0] operand1,
  input  logic [WIDTH-1:0] operand2,
  output logic             busy,
  output logic             complete,
  output logic [WIDTH-1:0] lo_next,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CNT_W = $clog2(WIDTH);

  alu_state_e state, state_next;

  logic [CNT_W-1:0]   cnt;
  logic [WIDTH-1:0]   work_hi;
  logic [WIDTH-1:0]   work_lo;
  logic [WIDTH-1:0]   op_mag;
  logic               neg_res;
  logic               neg_rem;
  logic               div_mode;

  logic               sgn;
  logic               div_zero;
  logic               launch;
  logic [WIDTH-1:0]   mag1;
  logic [WIDTH-1:0]   mag2;
  logic [WIDTH:0]     add_sum;
  logic [WIDTH:0]     rem_shift;
  logic [WIDTH:0]     rem_diff;
  logic [WIDTH-1:0]   hi_next;
  logic [2*WIDTH-1:0] prod_abs;
  logic [2*WIDTH-1:0] prod_fix;

  assign sgn      = is_signed_muldiv(operation);
  assign div_zero = is_div_op(operation) && (operand2 == '0);
  assign launch   = accept && (state == ST_IDLE) && is_muldiv_op(operation) && !div_zero;
  assign mag1     = (sgn && operand1[WIDTH-1]) ? -operand1 : operand1;
  assign mag2     = (sgn && operand2[WIDTH-1]) ? -operand2 : operand2;

  // Multiplier step: work_hi:work_lo is the partial product with the
  // unconsumed multiplier bits in the low half.
  assign add_sum   = {1'b0, work_hi} + (work_lo[0] ? {1'b0, op_mag} : '0);

  // Divider step: work_hi is the partial remainder, work_lo shifts the
  // dividend out of its top and the quotient bits into its bottom. The
  // remainder is always below the divisor, so rem_diff[WIDTH] is a clean
  // borrow flag.
  assign rem_shift = {work_hi, work_lo[WIDTH-1]};
  assign rem_diff  = rem_shift - {1'b0, op_mag};

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_next;
  end

  // Next-state logic
  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE: if (launch) state_next = is_div_op(operation) ? ST_DIV : ST_MUL;
      ST_MUL,
      ST_DIV:  if (cnt == '0) state_next = ST_SIGN;
      ST_SIGN: state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  // Outputs
  always_comb begin
    busy     = (state != ST_IDLE);
    complete = (state == ST_SIGN) || ((state == ST_IDLE) && accept && div_zero);
  end

  // Values committed to HI/LO when complete
  always_comb begin
    prod_abs = {work_hi, work_lo};
    prod_fix = neg_res ? -prod_abs : prod_abs;
    hi_next  = hi;
    lo_next  = lo;
    if (state == ST_SIGN) begin
      if (div_mode) begin
        lo_next = neg_res ? -work_lo : work_lo;
        hi_next = neg_rem ? -work_hi : work_hi;
      end else begin
        hi_next = prod_fix[2*WIDTH-1:WIDTH];
        lo_next = prod_fix[WIDTH-1:0];
      end
    end else if (div_zero) begin
      lo_next = '1;
      hi_next = operand1;
    end
  end

  // Iterative datapath and HI/LO
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt      <= '0;
      work_hi  <= '0;
      work_lo  <= '0;
      op_mag   <= '0;
      neg_res  <= 1'b0;
      neg_rem  <= 1'b0;
      div_mode <= 1'b0;
      hi       <= '0;
      lo       <= '0;
    end else begin
      if (launch) begin
        cnt      <= CNT_W'(WIDTH - 1);
        work_hi  <= '0;
        neg_res  <= sgn && (operand1[WIDTH-1] ^ operand2[WIDTH-1]);
        neg_rem  <= sgn && operand1[WIDTH-1];
        div_mode <= is_div_op(operation);
        if (is_div_op(operation)) begin
          work_lo <= mag1;
          op_mag  <= mag2;
        end else begin
          work_lo <= mag2;
          op_mag  <= mag1;
        end
      end else if (state == ST_MUL) begin
        cnt     <= cnt - 1'b1;
        work_hi <= add_sum[WIDTH:1];
        work_lo <= {add_sum[0], work_lo[WIDTH-1:1]};
      end else if (state == ST_DIV) begin
        cnt <= cnt - 1'b1;
        if (!rem_diff[WIDTH]) begin
          work_hi <= rem_diff[WIDTH-1:0];
          work_lo <= {work_lo[WIDTH-2:0], 1'b1};
        end else begin
          work_hi <= rem_shift[WIDTH-1:0];
          work_lo <= {work_lo[WIDTH-2:0], 1'b0};
        end
      end
      if (complete) begin
        hi <= hi_next;
        lo <= lo_next;
      end
    end
  end

endmodule

// File: rtl/multicycle_alu.sv
// Registered ALU with optional iterative multiply/divide and HI/LO.
//
// Build option: MULTICYCLE_ALU_MULDIV_EN
//   defined   - muldiv_unit instantiated; MULT/MULTU/DIV/DIVU iterate,
//               MFHI/MFLO read HI/LO
//   undefined - mult/div opcodes behave as undefined ops (result 0 next
//               cycle), hi/lo tied to 0, busy constant 0
//
// Ports:
//   clk, reset           clock, async active-high reset
//   start                launch; only sampled while busy=0
//   operation            4-bit opcode (see alu_pkg)
//   operand1, operand2   operands, latched on acceptance
//   result               registered result, held until the next done
//   zeroFlag             registered alongside result: result == 0
//   overflowFlag         signed overflow of ADD/SUB, registered
//   busy                 multi-cycle operation in progress
//   done                 one-cycle pulse when result/flags/HI/LO update
//   hi, lo               HI/LO registers
module multicycle_alu
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [3:0]       operation,
  input  logic [WIDTH-1:0] operand1,
  input  logic [WIDTH-1:0] operand2,
  output logic [WIDTH-1:0] result,
  output logic             zeroFlag,
  output logic             overflowFlag,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  logic             accept;
  logic             md_op;
  logic             md_complete;
  logic [WIDTH-1:0] md_lo_next;
  logic [WIDTH-1:0] sum;
  logic [WIDTH-1:0] diff;
  logic [WIDTH-1:0] basic_res;
  logic             basic_ovf;

  assign accept = start && !busy;

`ifdef MULTICYCLE_ALU_MULDIV_EN
  assign md_op = is_muldiv_op(operation);

  muldiv_unit #(.WIDTH(WIDTH)) u_muldiv (
    .clk       (clk),
    .reset     (reset),
    .accept    (accept),
    .operation (operation),
    .operand1  (operand1),
    .operand2  (operand2),
    .busy      (busy),
    .complete  (md_complete),
    .lo_next   (md_lo_next),
    .hi        (hi),
    .lo        (lo)
  );
`else
  assign md_op       = 1'b0;
  assign md_complete = 1'b0;
  assign md_lo_next  = '0;
  assign busy        = 1'b0;
  assign hi          = '0;
  assign lo          = '0;
`endif

  assign sum  = operand1 + operand2;
  assign diff = operand1 - operand2;

  // Single-cycle operations. Mult/div opcodes land in default when the
  // multiply/divide unit is not built, giving result 0.
  always_comb begin
    basic_res = '0;
    basic_ovf = 1'b0;
    case (operation)
      OP_AND:  basic_res = operand1 & operand2;
      OP_OR:   basic_res = operand1 | operand2;
      OP_XOR:  basic_res = operand1 ^ operand2;
      OP_NOR:  basic_res = ~(operand1 | operand2);
      OP_ADD: begin
        basic_res = sum;
        basic_ovf = (operand1[WIDTH-1] == operand2[WIDTH-1]) &&
                    (sum[WIDTH-1] != operand1[WIDTH-1]);
      end
      OP_SUB: begin
        basic_res = diff;
        basic_ovf = (operand1[WIDTH-1] != operand2[WIDTH-1]) &&
                    (diff[WIDTH-1] != operand1[WIDTH-1]);
      end
      OP_SLT:  basic_res = {{(WIDTH-1){1'b0}}, ($signed(operand1) < $signed(operand2))};
      OP_SLTU: basic_res = {{(WIDTH-1){1'b0}}, (operand1 < operand2)};
      OP_MFHI: basic_res = hi;
      OP_MFLO: basic_res = lo;
      default: basic_res = '0;
    endcase
  end

  // Result register and done pulse. Mult/div results arrive through
  // md_complete, either from the SIGN state or from a divide by zero
  // accepted this cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      result       <= '0;
      zeroFlag     <= 1'b0;
      overflowFlag <= 1'b0;
      done         <= 1'b0;
    end else begin
      done <= 1'b0;
      if (accept && !md_op) begin
        result       <= basic_res;
        zeroFlag     <= (basic_res == '0);
        overflowFlag <= basic_ovf;
        done         <= 1'b1;
      end else if (md_complete) begin
        result       <= md_lo_next;
        zeroFlag     <= (md_lo_next == '0);
        overflowFlag <= 1'b0;
        done         <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_multicycle_alu.sv
module tb_multicycle_alu;

  localparam int W = 32;
`ifdef MULTICYCLE_ALU_MULDIV_EN
  localparam bit MD = 1'b1;
`else
  localparam bit MD = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         start = 1'b0;
  logic [3:0]   operation = '0;
  logic [W-1:0] operand1 = '0;
  logic [W-1:0] operand2 = '0;
  logic [W-1:0] result;
  logic         zeroFlag;
  logic         overflowFlag;
  logic         busy;
  logic         done;
  logic [W-1:0] hi;
  logic [W-1:0] lo;

  int n_vec = 0;
  int n_bad = 0;

  // reference HI/LO
  logic [W-1:0] m_hi = '0;
  logic [W-1:0] m_lo = '0;

  multicycle_alu #(.WIDTH(W)) dut (
    .clk          (clk),
    .reset        (reset),
    .start        (start),
    .operation    (operation),
    .operand1     (operand1),
    .operand2     (operand2),
    .result       (result),
    .zeroFlag     (zeroFlag),
    .overflowFlag (overflowFlag),
    .busy         (busy),
    .done         (done),
    .hi           (hi),
    .lo           (lo)
  );

  always #5 clk = ~clk;

  // Behavioural model: plain 64-bit arithmetic. Updates m_hi/m_lo for
  // mult/div and returns the expected result, overflow and done latency.
  task automatic model(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                       output logic [W-1:0] r, output logic ov, output int lat);
    longint       s;
    longint       q;
    longint       rm;
    logic [63:0]  p;
    r   = '0;
    ov  = 1'b0;
    lat = 1;
    case (op)
      4'b0000: r = a & b;
      4'b0001: r = a | b;
      4'b0011: r = a ^ b;
      4'b1100: r = ~(a | b);
      4'b0010: begin
        s  = longint'($signed(a)) + longint'($signed(b));
        r  = a + b;
        ov = (s > 64'sd2147483647) || (s < -64'sd2147483648);
      end
      4'b0110: begin
        s  = longint'($signed(a)) - longint'($signed(b));
        r  = a - b;
        ov = (s > 64'sd2147483647) || (s < -64'sd2147483648);
      end
      4'b0111: r = ($signed(a) < $signed(b)) ? 1 : 0;
      4'b1000: r = (a < b) ? 1 : 0;
      4'b1110: r = m_hi;
      4'b1111: r = m_lo;
      4'b1001, 4'b1010: if (MD) begin
        if (op == 4'b1001) begin
          s = longint'($signed(a)) * longint'($signed(b));
          p = s;
        end else begin
          p = {32'b0, a} * {32'b0, b};
        end
        m_hi = p[63:32];
        m_lo = p[31:0];
        r    = m_lo;
        lat  = W + 2;
      end
      4'b1011, 4'b1101: if (MD) begin
        if (b == 0) begin
          m_lo = '1;
          m_hi = a;
        end else begin
          if (op == 4'b1011) begin
            q  = longint'($signed(a)) / longint'($signed(b));
            rm = longint'($signed(a)) % longint'($signed(b));
          end else begin
            q  = longint'({32'b0, a}) / longint'({32'b0, b});
            rm = longint'({32'b0, a}) % longint'({32'b0, b});
          end
          m_lo = q[31:0];
          m_hi = rm[31:0];
          lat  = W + 2;
        end
        r = m_lo;
      end
      default: r = '0;
    endcase
  endtask

  // One operation: start for one cycle, scramble inputs, wait for done
  // (bounded), then compare latency, busy profile, result, flags, HI/LO.
  // With b2b set the start is driven in the current (done) cycle.
  task automatic do_op(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                       input bit b2b);
    logic [W-1:0] exp_r;
    logic         exp_ov;
    int           lat;
    int           cyc;
    bit           busy_ok;
    model(op, a, b, exp_r, exp_ov, lat);
    if (!b2b) @(negedge clk);
    operation = op;
    operand1  = a;
    operand2  = b;
    start     = 1'b1;
    @(negedge clk);
    start     = 1'b0;
    operand1  = $urandom;
    operand2  = $urandom;
    operation = 4'($urandom_range(0, 15));
    cyc       = 1;
    busy_ok   = 1'b1;
    while (done !== 1'b1 && cyc < 200) begin
      if (busy !== (lat > 1)) busy_ok = 1'b0;
      @(negedge clk);
      cyc++;
    end
    n_vec++;
    if (cyc !== lat) begin
      n_bad++;
      $display("FAIL latency op=%b a=%h b=%h: done after %0d cycles, expected %0d", op, a, b, cyc, lat);
    end
    n_vec++;
    if (!busy_ok || busy !== 1'b0) begin
      n_bad++;
      $display("FAIL busy op=%b a=%h b=%h: busy profile wrong (busy at done=%b), expected %0d busy cycles",
               op, a, b, busy, lat - 1);
    end
    n_vec++;
    if (result !== exp_r) begin
      n_bad++;
      $display("FAIL result op=%b a=%h b=%h: got %h expected %h", op, a, b, result, exp_r);
    end
    n_vec++;
    if (overflowFlag !== exp_ov || zeroFlag !== (exp_r == 0)) begin
      n_bad++;
      $display("FAIL flags op=%b a=%h b=%h: got ovf=%b zero=%b expected ovf=%b zero=%b",
               op, a, b, overflowFlag, zeroFlag, exp_ov, (exp_r == 0));
    end
    n_vec++;
    if (hi !== m_hi || lo !== m_lo) begin
      n_bad++;
      $display("FAIL hilo op=%b a=%h b=%h: got hi=%h lo=%h expected hi=%h lo=%h",
               op, a, b, hi, lo, m_hi, m_lo);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) @(negedge clk);
    n_vec++;
    if ({result, zeroFlag, overflowFlag, busy, done, hi, lo} !== '0) begin
      n_bad++;
      $display("FAIL reset: result=%h zero=%b ovf=%b busy=%b done=%b hi=%h lo=%h, expected all 0",
               result, zeroFlag, overflowFlag, busy, done, hi, lo);
    end
    reset = 1'b0;
  endtask

  task automatic test_directed();
    do_op(4'b0010, 32'h7FFFFFFF, 32'h00000001, 1'b0);   // ADD overflow
    do_op(4'b0110, 32'd5, 32'd5, 1'b0);                 // SUB -> zero
    do_op(4'b0111, 32'hFFFFFFFF, 32'd1, 1'b0);          // SLT -> 1
    do_op(4'b1000, 32'hFFFFFFFF, 32'd1, 1'b0);          // SLTU -> 0
    do_op(4'b0100, 32'h12345678, 32'h9ABCDEF0, 1'b0);   // undefined
    do_op(4'b0101, 32'hFFFFFFFF, 32'h1, 1'b0);          // undefined
    do_op(4'b0110, 32'h80000000, 32'h00000001, 1'b0);   // SUB overflow
    do_op(4'b1001, 32'hFFFFFFFD, 32'd7, 1'b0);          // MULT -3*7
    do_op(4'b1111, 32'h0, 32'h0, 1'b0);                 // MFLO
    do_op(4'b1110, 32'h0, 32'h0, 1'b0);                 // MFHI
    do_op(4'b1101, 32'd100, 32'd7, 1'b0);               // DIVU
    do_op(4'b1011, 32'hFFFFFFF9, 32'd2, 1'b0);          // DIV -7/2
    do_op(4'b1011, 32'd9, 32'd0, 1'b0);                 // DIV by zero
    do_op(4'b1010, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0);   // MULTU max
    do_op(4'b1011, 32'h80000000, 32'hFFFFFFFF, 1'b0);   // DIV min/-1
  endtask

  task automatic test_random();
    logic [3:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    for (int i = 0; i < 60; i++) begin
      op = 4'($urandom_range(0, 15));
      a  = $urandom;
      b  = $urandom;
      if ($urandom_range(0, 3) == 0) b = b >> $urandom_range(0, 31);
      if ($urandom_range(0, 7) == 0) b = '0;
      do_op(op, a, b, 1'b0);
    end
  endtask

  task automatic test_back_to_back();
    do_op(4'b1001, $urandom, $urandom, 1'b0);
    do_op(4'b0010, $urandom, $urandom, 1'b1);
    do_op(4'b1101, $urandom, 32'd13, 1'b1);
    do_op(4'b1110, 32'h0, 32'h0, 1'b1);
    do_op(4'b1111, 32'h0, 32'h0, 1'b1);
  endtask

`ifdef MULTICYCLE_ALU_MULDIV_EN
  // A second start while busy must be ignored and operand changes after
  // acceptance must not matter.
  task automatic test_ignore_start();
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] exp_r;
    logic         exp_ov;
    int           lat;
    int           cyc;
    a = $urandom;
    b = $urandom;
    model(4'b1001, a, b, exp_r, exp_ov, lat);
    @(negedge clk);
    operation = 4'b1001; operand1 = a; operand2 = b; start = 1'b1;
    @(negedge clk);
    start = 1'b0; operand1 = $urandom; operand2 = $urandom;
    cyc = 1;
    repeat (4) begin
      @(negedge clk);
      cyc++;
    end
    operation = 4'b0010; operand1 = $urandom; operand2 = $urandom; start = 1'b1;
    @(negedge clk);
    cyc++;
    start = 1'b0; operation = 4'b1101;
    while (done !== 1'b1 && cyc < 200) begin
      @(negedge clk);
      cyc++;
    end
    n_vec++;
    if (cyc !== lat || result !== exp_r || hi !== m_hi || lo !== m_lo) begin
      n_bad++;
      $display("FAIL ignore_start: done at %0d result=%h hi=%h lo=%h, expected %0d %h %h %h",
               cyc, result, hi, lo, lat, exp_r, m_hi, m_lo);
    end
  endtask
`endif

  // MULTU launched, extra start at N+5, asynchronous reset at N+10.
  task automatic test_reset_mid();
    @(negedge clk);
    operation = 4'b1010; operand1 = $urandom | 1; operand2 = $urandom | 1; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    operation = 4'b0010; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    n_vec++;
    if (busy !== MD) begin
      n_bad++;
      $display("FAIL busy_before_reset: got %b expected %b", busy, MD);
    end
    @(negedge clk);
    reset = 1'b1;
    #1;
    n_vec++;
    if ({busy, done, hi, lo, result} !== '0) begin
      n_bad++;
      $display("FAIL reset_mid: busy=%b done=%b hi=%h lo=%h result=%h, expected all 0",
               busy, done, hi, lo, result);
    end
    m_hi = '0;
    m_lo = '0;
    @(negedge clk);
    reset = 1'b0;
    do_op(4'b1110, 32'h0, 32'h0, 1'b0);
    do_op(4'b1111, 32'h0, 32'h0, 1'b0);
  endtask

  initial begin
    test_reset();
    test_directed();
    test_back_to_back();
`ifdef MULTICYCLE_ALU_MULDIV_EN
    test_ignore_start();
`endif
    test_random();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
